// File: rtl/colour_seq_pkg.sv
// Shared types, colour constants and colour wrap helpers for colour_sequencer.
// Latency: combinational helpers only, no state.
// Backpressure: not applicable; used by the sequencer and its bench-free logic.
package colour_seq_pkg;

    typedef enum logic [1:0] {
        LOCKOUT = 2'd0,
        IDLE    = 2'd1,
        PRESSED = 2'd2,
        REPEAT  = 2'd3
    } state_t;

    localparam logic [2:0] COL_OFF   = 3'b000;
    localparam logic [2:0] COL_FIRST = 3'b001;
    localparam logic [2:0] COL_LAST  = 3'b110;

    // Up step: 001..110 then wrap to 001. Off (and the unused 111) land on 001.
    function automatic logic [2:0] colour_next(input logic [2:0] c);
        logic [2:0] n;
        if ((c == COL_OFF) || (c >= COL_LAST)) begin
            n = COL_FIRST;
        end else begin
            n = c + 3'd1;
        end
        return n;
    endfunction

    // Down step: 110..001 then wrap to 110. Off (and the unused 111) land on 110.
    function automatic logic [2:0] colour_prev(input logic [2:0] c);
        logic [2:0] p;
        if ((c == COL_OFF) || (c == COL_FIRST) || (c > COL_LAST)) begin
            p = COL_LAST;
        end else begin
            p = c - 3'd1;
        end
        return p;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Level debouncer: output follows input only after DEBOUNCE_CYCLES equal samples.
// Latency: DEBOUNCE_CYCLES clock edges from a stable input change to o_level.
// Backpressure: none; pulses shorter than DEBOUNCE_CYCLES are dropped.
//
// Ports:
//   i_clk    core clock (rising edge)
//   i_rst_n  asynchronous active-low reset
//   i_level  already-synchronised input level
//   o_level  debounced level (reset 0)
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_level
);

    localparam int         CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_level;

    // r_cnt counts consecutive samples that disagree with r_level; any
    // agreeing sample restarts the count, so a glitch never accumulates.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (i_level == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == TC) begin
            r_level <= i_level;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/colour_sequencer.sv
// Button-driven 3-bit colour stepper with hold-to-auto-repeat.
// Latency: press steps colour on the 3rd edge after button is sampled high (+DEBOUNCE_CYCLES with debounce).
// Backpressure: none; step is a one-cycle strobe that the consumer must accept.
//
// Ports:
//   clk     single clock, rising edge
//   rst     asynchronous active-low reset
//   button  raw push-button (asynchronous)
//   dir     step direction, 1 = up, 0 = down (quasi-static, asynchronous)
//   colour  registered colour code, 000 after reset, then 001..110
//   step    one-cycle strobe, high in the cycle colour takes a new value
// Build option: define COLOUR_SEQ_DEBOUNCE_EN to insert button_debouncer
// after the button synchroniser; otherwise the synchroniser drives btn_db.
module colour_sequencer
    import colour_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    input  logic       dir,
    output logic [2:0] colour,
    output logic       step
);

    localparam int            MAX_CYC   = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int            CW        = $clog2(MAX_CYC);
    localparam logic [CW-1:0] HOLD_TC   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_CYCLES - 1);

    logic          r_btn_meta;
    logic          r_btn_sync;
    logic          r_dir_meta;
    logic          r_dir_sync;
    logic          r_armed;
    logic          w_btn_db;
    logic [2:0]    w_col_stepped;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_colour;
    logic          r_step;

    // Two-flop synchronisers for both asynchronous inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
            r_dir_meta <= 1'b0;
            r_dir_sync <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_btn_meta <= button;
            r_btn_sync <= r_btn_meta;
            r_dir_meta <= dir;
            r_dir_sync <= r_dir_meta;
            r_armed    <= 1'b1;
        end
    end

`ifdef COLOUR_SEQ_DEBOUNCE_EN
    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_level (r_btn_sync),
        .o_level (w_btn_db)
    );
`else
    logic [31:0] w_unused_db;
    assign w_unused_db = DEBOUNCE_CYCLES;
    assign w_btn_db    = r_btn_sync;
`endif

    assign w_col_stepped = r_dir_sync ? colour_next(r_colour) : colour_prev(r_colour);

    // The reset-zeroed synchroniser reads 0 for the first edges after reset
    // even if the button is held, so LOCKOUT only trusts a low reading once
    // the first post-reset sample has reached the metastability flop and the
    // whole input path (meta, sync, debounced) agrees the button is up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= LOCKOUT;
            r_cnt    <= '0;
            r_colour <= COL_OFF;
            r_step   <= 1'b0;
        end else begin
            r_step <= 1'b0;
            case (r_state)
                LOCKOUT: begin
                    if (r_armed && !r_btn_meta && !r_btn_sync && !w_btn_db) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    if (w_btn_db) begin
                        r_colour <= w_col_stepped;
                        r_step   <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= PRESSED;
                    end
                end
                PRESSED: begin
                    // Release is tested first so it beats a coincident expiry.
                    if (!w_btn_db) begin
                        r_state <= IDLE;
                    end else if (r_cnt == HOLD_TC) begin
                        r_colour <= w_col_stepped;
                        r_step   <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= REPEAT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                REPEAT: begin
                    if (!w_btn_db) begin
                        r_state <= IDLE;
                    end else if (r_cnt == REPEAT_TC) begin
                        r_colour <= w_col_stepped;
                        r_step   <= 1'b1;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= LOCKOUT;
                end
            endcase
        end
    end

    assign colour = r_colour;
    assign step   = r_step;

endmodule
